// File: rtl/exec_unit_pipe.sv
// Execute stage: WIDTH-bit ALU, iterative signed multiplier and branch resolution behind
// valid/ready handshakes. Define EXEC_DIV_EN to add an iterative unsigned divider (alu_func 11).
module exec_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 32,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_func,
  input  logic [2:0]         br_cond,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic [SHW-1:0]     shamt,
  input  logic [AW-1:0]      br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero_flag,
  output logic               br_taken,
  output logic [AW-1:0]      br_addr,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] FnAdd = 4'd0, FnSub = 4'd1, FnAnd = 4'd2, FnOr  = 4'd3,
                         FnXor = 4'd4, FnNor = 4'd5, FnSll = 4'd6, FnSrl = 4'd7,
                         FnSra = 4'd8, FnSlt = 4'd9, FnMul = 4'd10;
`ifdef EXEC_DIV_EN
  localparam logic [3:0] FnDiv = 4'd11;
`endif
  localparam logic [2:0] BrEq = 3'd1, BrNeq = 3'd2, BrGtz = 3'd3, BrLez = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDone = 2'd2
`ifdef EXEC_DIV_EN
    , StDiv = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic               neg_q, neg_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d, load_res;
  logic               br_taken_q, br_taken_d;
  logic [AW-1:0]      br_addr_q, br_addr_d;

  logic [WIDTH-1:0]   b_opnd, alu_res, a_mag, b_mag;
  logic               br_hit, accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod, mul_final;

  assign b_opnd = use_imm ? imm : op2;
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (alu_func)
      FnAdd:   alu_res = op1 + b_opnd;
      FnSub:   alu_res = op1 - b_opnd;
      FnAnd:   alu_res = op1 & b_opnd;
      FnOr:    alu_res = op1 | b_opnd;
      FnXor:   alu_res = op1 ^ b_opnd;
      FnNor:   alu_res = ~(op1 | b_opnd);
      FnSll:   alu_res = b_opnd << shamt;
      FnSrl:   alu_res = b_opnd >> shamt;
      FnSra:   alu_res = $signed(b_opnd) >>> shamt;
      FnSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(b_opnd)};
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses op2, never the immediate.
  always_comb begin
    br_hit = 1'b0;
    case (br_cond)
      BrEq:    br_hit = (op1 == op2);
      BrNeq:   br_hit = (op1 != op2);
      BrGtz:   br_hit = !op1[WIDTH-1] && (op1 != '0);
      BrLez:   br_hit = op1[WIDTH-1] || (op1 == '0);
      default: br_hit = 1'b0;
    endcase
  end

  // Multiply on magnitudes with a right-shifting {hi, lo} product; sign fixed up at the end.
  assign a_mag     = op1[WIDTH-1] ? -op1 : op1;
  assign b_mag     = b_opnd[WIDTH-1] ? -b_opnd : b_opnd;
  assign mul_sum   = {1'b0, hi_q} + ({1'b0, b_q} & {(WIDTH+1){lo_q[0]}});
  assign mul_prod  = {hi_q, lo_q};
  assign mul_final = neg_q ? -mul_prod : mul_prod;

`ifdef EXEC_DIV_EN
  // Restoring divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, b_q};
  assign div_rem = div_ge ? WIDTH'(div_sh - {1'b0, b_q}) : div_sh[WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    load_res    = 1'b0;
    br_taken_d  = br_taken_q;
    br_addr_d   = br_addr_q;
    case (state_q)
      StIdle: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          br_taken_d = br_hit;
          br_addr_d  = br_hit ? br_target : '0;
          if (alu_func == FnMul) begin
            state_d     = StMult;
            cnt_d       = '0;
            hi_d        = '0;
            lo_d        = a_mag;
            b_d         = b_mag;
            neg_d       = op1[WIDTH-1] ^ b_opnd[WIDTH-1];
            out_valid_d = 1'b0;
`ifdef EXEC_DIV_EN
          end else if (alu_func == FnDiv) begin
            state_d     = StDiv;
            cnt_d       = '0;
            hi_d        = '0;
            lo_d        = op1;
            b_d         = b_opnd;
            out_valid_d = 1'b0;
`endif
          end else begin
            out_valid_d = 1'b1;
            result_d    = {{WIDTH{1'b0}}, alu_res};
            load_res    = 1'b1;
          end
        end
      end
      StMult: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = mul_final;
          load_res    = 1'b1;
        end else begin
          hi_d  = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef EXEC_DIV_EN
      StDiv: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = {hi_q, lo_q};
          load_res    = 1'b1;
        end else begin
          hi_d  = div_rem;
          lo_d  = {lo_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    zero_d = load_res ? (result_d == '0) : zero_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      br_taken_q  <= 1'b0;
      br_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      br_taken_q  <= br_taken_d;
      br_addr_q   <= br_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign br_taken  = br_taken_q;
  assign br_addr   = br_addr_q;
`ifdef EXEC_DIV_EN
  assign busy = (state_q == StMult) || (state_q == StDiv);
`else
  assign busy = (state_q == StMult);
`endif

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe (WIDTH=32): vector table for single-cycle ops, hand-written
// sequences for MUL/DIV latency, output stall and asynchronous reset during a multiply.
module tb_exec_unit_pipe;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned SHW   = 5;
  localparam int NV = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [3:0]       alu_func;
  logic [2:0]       br_cond;
  logic [WIDTH-1:0] op1, op2, imm;
  logic             use_imm;
  logic [SHW-1:0]   shamt;
  logic [AW-1:0]    br_target;
  logic             out_valid, out_ready;
  logic [63:0]      result;
  logic             zero_flag, br_taken, busy;
  logic [AW-1:0]    br_addr;

  exec_unit_pipe #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_func(alu_func), .br_cond(br_cond), .op1(op1), .op2(op2), .imm(imm),
    .use_imm(use_imm), .shamt(shamt), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero_flag(zero_flag), .br_taken(br_taken),
    .br_addr(br_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  func;
    logic [2:0]  cond;
    logic [31:0] a, b, im;
    logic        ui;
    logic [4:0]  sh;
    logic [31:0] tg;
    logic [63:0] r;
    logic        z;
    logic        tk;
    logic [31:0] ad;
  } vec_t;

  vec_t vecs[NV];
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic [2:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic ui,
                              input logic [4:0] sh, input logic [31:0] tg, input logic [63:0] r,
                              input logic tk, input logic [31:0] ad);
    vec_t v;
    v.func = f; v.cond = c; v.a = a; v.b = b; v.im = im; v.ui = ui; v.sh = sh; v.tg = tg;
    v.r = r; v.z = (r == 64'd0); v.tk = tk; v.ad = ad;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alu_func = v.func; br_cond = v.cond; op1 = v.a; op2 = v.b; imm = v.im;
    use_imm = v.ui; shamt = v.sh; br_target = v.tg;
  endtask

  // Presents one op with in_valid high and checks the bundle one edge later.
  task automatic apply_vec(input vec_t v, input string name);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check({name, " valid"}, out_valid, 1);
    check({name, " result"}, result, v.r);
    check({name, " zero"}, zero_flag, v.z);
    check({name, " taken"}, br_taken, v.tk);
    check({name, " addr"}, br_addr, v.ad);
  endtask

  task automatic run_multi(input string name, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int lat = 0;
    bit bad = 1'b0;
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check({name, " in_ready before"}, in_ready, 1);
    alu_func = f; op1 = a; op2 = b; use_imm = 1'b0; br_cond = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready || !busy) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " stalled+busy"}, bad, 0);
    check({name, " latency"}, lat, 33);
    check({name, " result"}, result, exp);
    check({name, " zero"}, zero_flag, exp == 64'd0);
    check({name, " busy done"}, busy, 0);
    @(posedge clk); #1;
    check({name, " no dup"}, out_valid, 0);
  endtask

  initial begin
    vecs[0]  = mk(4'd0, 3'd0, 7, 5, 0, 1'b0, 5'd0, 0, 64'd12, 1'b0, 0);
    vecs[1]  = mk(4'd1, 3'd0, 3, 5, 0, 1'b0, 5'd0, 0, 64'hFFFF_FFFE, 1'b0, 0);
    vecs[2]  = mk(4'd8, 3'd0, 0, 32'h8000_0000, 0, 1'b0, 5'd4, 0, 64'hF800_0000, 1'b0, 0);
    vecs[3]  = mk(4'd9, 3'd0, 32'hFFFF_FFFF, 1, 0, 1'b0, 5'd0, 0, 64'd1, 1'b0, 0);
    vecs[4]  = mk(4'd5, 3'd0, 0, 0, 0, 1'b0, 5'd0, 0, 64'hFFFF_FFFF, 1'b0, 0);
    vecs[5]  = mk(4'd0, 3'd1, 9, 9, 0, 1'b0, 5'd0, 32'h400, 64'd18, 1'b1, 32'h400);
    vecs[6]  = mk(4'd0, 3'd2, 9, 9, 0, 1'b0, 5'd0, 32'h400, 64'd18, 1'b0, 0);
    vecs[7]  = mk(4'd2, 3'd1, 32'hF0F0, 32'hF0F0, 32'h0FF0, 1'b1, 5'd0, 32'h88, 64'h00F0,
                  1'b1, 32'h88);
    vecs[8]  = mk(4'd4, 3'd0, 32'hAAAA, 32'hAAAA, 0, 1'b0, 5'd0, 0, 64'd0, 1'b0, 0);
    vecs[9]  = mk(4'd6, 3'd0, 0, 1, 0, 1'b0, 5'd31, 0, 64'h8000_0000, 1'b0, 0);
    vecs[10] = mk(4'd7, 3'd0, 0, 32'h8000_0000, 0, 1'b0, 5'd4, 0, 64'h0800_0000, 1'b0, 0);
    vecs[11] = mk(4'd3, 3'd0, 32'h1200, 32'h0034, 0, 1'b0, 5'd0, 0, 64'h1234, 1'b0, 0);
    vecs[12] = mk(4'd15, 3'd0, 5, 5, 0, 1'b0, 5'd0, 0, 64'd0, 1'b0, 0);
    vecs[13] = mk(4'd0, 3'd3, 5, 0, 0, 1'b0, 5'd0, 32'h10, 64'd5, 1'b1, 32'h10);
    vecs[14] = mk(4'd0, 3'd4, 0, 0, 0, 1'b0, 5'd0, 32'h20, 64'd0, 1'b1, 32'h20);
    vecs[15] = mk(4'd0, 3'd3, 32'h8000_0000, 0, 0, 1'b0, 5'd0, 32'h30, 64'h8000_0000, 1'b0, 0);
    vecs[16] = mk(4'd0, 3'd7, 1, 1, 0, 1'b0, 5'd0, 32'h44, 64'd2, 1'b0, 0);
    vecs[17] = mk(4'd9, 3'd0, 32'h8000_0000, 1, 0, 1'b0, 5'd0, 0, 64'd1, 1'b0, 0);
    vecs[18] = mk(4'd9, 3'd0, 1, 32'h8000_0000, 0, 1'b0, 5'd0, 0, 64'd0, 1'b0, 0);
    vecs[19] = mk(4'd0, 3'd0, 32'hFFFF_FFFF, 1, 0, 1'b0, 5'd0, 0, 64'd0, 1'b0, 0);

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_func = 4'd0; br_cond = 3'd0; op1 = '0; op2 = '0; imm = '0; use_imm = 1'b0;
    shamt = '0; br_target = '0;
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset zero", zero_flag, 0);
    check("reset taken", br_taken, 0);
    check("reset addr", br_addr, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    reset = 1'b1;

    // Back-to-back issue: every vector must appear the very next cycle.
    for (int i = 0; i < NV; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain valid", out_valid, 0);

`ifdef EXEC_DIV_EN
    run_multi("div 100/7", 4'd11, 100, 7, {32'd2, 32'd14});
    run_multi("div by 0", 4'd11, 1234, 0, {32'd1234, 32'hFFFF_FFFF});
`else
    apply_vec(mk(4'd11, 3'd0, 100, 7, 0, 1'b0, 5'd0, 0, 64'd0, 1'b0, 0), "func11 undef");
    in_valid = 1'b0;
    @(posedge clk); #1;
`endif

    run_multi("mul -3x7", 4'd10, 32'hFFFF_FFFD, 7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_multi("mul min*min", 4'd10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_multi("mul 6x-2", 4'd10, 6, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF4);
    run_multi("mul x0", 4'd10, 32'h1234_5678, 0, 64'd0);

    // Output stall: bundle held, next op waits and is not lost.
    out_ready = 1'b0;
    drive(mk(4'd0, 3'd0, 7, 5, 0, 1'b0, 5'd0, 0, 64'd12, 1'b0, 0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(mk(4'd1, 3'd0, 10, 4, 0, 1'b0, 5'd0, 0, 64'd6, 1'b0, 0));
    for (int i = 0; i < 5; i++) begin
      check("stall valid", out_valid, 1);
      check("stall result", result, 64'd12);
      check("stall in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("after stall valid", out_valid, 1);
    check("after stall result", result, 64'd6);
    @(posedge clk); #1;
    check("after stall no dup", out_valid, 0);

    // Asynchronous reset in the middle of a multiply, with a taken branch pending.
    drive(mk(4'd10, 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 0, 1'b0, 5'd0, 32'h55, 64'd0, 1'b0, 0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid-mul busy", busy, 1);
    check("mid-mul taken", br_taken, 1);
    #2 reset = 1'b0;
    #1;
    check("async rst valid", out_valid, 0);
    check("async rst result", result, 0);
    check("async rst zero", zero_flag, 0);
    check("async rst taken", br_taken, 0);
    check("async rst addr", br_addr, 0);
    check("async rst busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    apply_vec(mk(4'd0, 3'd0, 7, 5, 0, 1'b0, 5'd0, 0, 64'd12, 1'b0, 0), "post-reset add");
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
